// File: rtl/rv_mem_arbiter.sv
// Shares one 32-bit memory bus between instruction fetch and the load/store port.
// Data has priority, a burst limit keeps fetch moving, and a per-transfer timeout turns a hung slave into an error.
module rv_mem_arbiter #(
    parameter int unsigned DATA_BURST_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_ibus_addr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_data,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    input  logic [31:0] i_dbus_addr,
    input  logic        i_dbus_cyc,
    input  logic        i_dbus_we,
    input  logic [3:0]  i_dbus_sel,
    input  logic [31:0] i_dbus_data,
    output logic [31:0] o_dbus_data,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_cyc,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_data,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_ack,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX_C = 4'(DATA_BURST_MAX);
    localparam logic       TMO_EN_C    = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [7:0] TMO_LAST_C  = 8'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      pick_s;
    logic [3:0]  burst_cnt_r;
    logic [3:0]  burst_nxt_s;
    logic [7:0]  tmo_cnt_r;
    logic [7:0]  tmo_nxt_s;
    logic [31:0] ibus_data_r;
    logic [31:0] dbus_data_r;
    logic        granted_s;
    logic        owner_cyc_s;
    logic        done_s;
    logic        abort_s;
    logic        timeout_s;
    logic        ibus_done_s;
    logic        dbus_done_s;

    // Decode current owner and classify this cycle as completion, abort or timeout
    always_comb begin
        granted_s   = 1'b0;
        owner_cyc_s = 1'b0;
        case (state_r)
            ST_IBUS: begin
                granted_s   = 1'b1;
                owner_cyc_s = i_ibus_cyc;
            end
            ST_DBUS: begin
                granted_s   = 1'b1;
                owner_cyc_s = i_dbus_cyc;
            end
            default: begin
                granted_s   = 1'b0;
                owner_cyc_s = 1'b0;
            end
        endcase
        done_s      = granted_s & owner_cyc_s & i_mem_ack & ~i_reset;
        abort_s     = granted_s & ~owner_cyc_s;
        timeout_s   = TMO_EN_C & granted_s & owner_cyc_s & ~i_mem_ack & ~i_reset
                      & (tmo_cnt_r == TMO_LAST_C);
        ibus_done_s = done_s & (state_r == ST_IBUS);
        dbus_done_s = done_s & (state_r == ST_DBUS);
    end

    // Burst count including this cycle's completion, so the limit yields exactly DATA_BURST_MAX data grants
    always_comb begin
        burst_nxt_s = burst_cnt_r;
        if (!i_ibus_cyc) begin
            burst_nxt_s = 4'd0;
        end else if (ibus_done_s) begin
            burst_nxt_s = 4'd0;
        end else if (dbus_done_s && (burst_cnt_r < BURST_MAX_C)) begin
            burst_nxt_s = burst_cnt_r + 4'd1;
        end else begin
            burst_nxt_s = burst_cnt_r;
        end
    end

    // Arbitration pick from live requests
    always_comb begin
        pick_s = ST_IDLE;
        case ({i_dbus_cyc, i_ibus_cyc})
            2'b10:   pick_s = ST_DBUS;
            2'b01:   pick_s = ST_IBUS;
            2'b11:   pick_s = (burst_nxt_s < BURST_MAX_C) ? ST_DBUS : ST_IBUS;
            default: pick_s = ST_IDLE;
        endcase
    end

    // Next-state and timeout counter update
    always_comb begin
        state_nxt_s = state_r;
        if (i_reset) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = pick_s;
                ST_IBUS, ST_DBUS: begin
                    if (abort_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (done_s) begin
                        state_nxt_s = pick_s;
                    end else if (timeout_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end

        tmo_nxt_s = 8'd0;
        if (done_s || (state_nxt_s != state_r)) begin
            tmo_nxt_s = 8'd0;
        end else if (granted_s) begin
            tmo_nxt_s = tmo_cnt_r + 8'd1;
        end else begin
            tmo_nxt_s = 8'd0;
        end
    end

    // State, counters and per-port read-data hold registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= 4'd0;
            tmo_cnt_r   <= 8'd0;
            ibus_data_r <= 32'd0;
            dbus_data_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            burst_cnt_r <= burst_nxt_s;
            tmo_cnt_r   <= tmo_nxt_s;
            if (ibus_done_s) begin
                ibus_data_r <= i_mem_data;
            end
            if (dbus_done_s) begin
                dbus_data_r <= i_mem_data;
            end
        end
    end

    // Bus mux from the owner's live inputs; read data passes straight through on ack
    always_comb begin
        o_mem_addr = 32'd0;
        o_mem_cyc  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_sel  = 4'd0;
        o_mem_data = 32'd0;
        case (state_r)
            ST_IBUS: begin
                o_mem_addr = i_ibus_addr;
                o_mem_cyc  = i_ibus_cyc & ~i_reset;
                o_mem_we   = 1'b0;
                o_mem_sel  = 4'hF;
                o_mem_data = 32'd0;
            end
            ST_DBUS: begin
                o_mem_addr = i_dbus_addr;
                o_mem_cyc  = i_dbus_cyc & ~i_reset;
                o_mem_we   = i_dbus_we;
                o_mem_sel  = i_dbus_sel;
                o_mem_data = i_dbus_data;
            end
            default: begin
                o_mem_addr = 32'd0;
                o_mem_cyc  = 1'b0;
            end
        endcase
        o_grant     = {state_r == ST_DBUS, state_r == ST_IBUS};
        o_ibus_ack  = ibus_done_s;
        o_dbus_ack  = dbus_done_s;
        o_ibus_err  = timeout_s & (state_r == ST_IBUS);
        o_dbus_err  = timeout_s & (state_r == ST_DBUS);
        o_ibus_data = ibus_done_s ? i_mem_data : ibus_data_r;
        o_dbus_data = dbus_done_s ? i_mem_data : dbus_data_r;
    end

endmodule
